line_bit_recovery: RTL and testbench
====================================

Name: line_bit_recovery

Overview:
Upstream stage of the 3-ones sequence recognizer. It oversamples an asynchronous serial line coded as NRZ or RZ, recovers bit timing, and presents one decoded bit per bit period. d_out feeds the recognizer's d_in and d_valid feeds its en. It also flags RZ coding violations and loss of lock.

Parameters:
OSR, 8, clock cycles per bit period; multiple of 4, at least 4.
MAX_RUN, 15, edge-free bit periods tolerated before lock is dropped; at least 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
line_in  input  1  asynchronous serial line
rz_mode  input  1  0 = NRZ, 1 = RZ; may change only while enable is 0
enable  input  1  decoder enable; 0 forces IDLE
d_out  output  1  last decoded bit; held between valids
d_valid  output  1  one-cycle strobe, new bit on d_out
framing_err  output  1  one-cycle strobe, RZ violation
locked  output  1  high while in TRACK

Behaviour:
- Reset (asynchronous, rst_n=0):
  - d_out=0, d_valid=0, framing_err=0, locked=0.
  - Synchronizer flops=0, phase=0, run=0, state=IDLE.
- Input path: 2-FF synchronizer produces s2. A third flop holds s3 = previous s2.
- Edge definitions (combinational):
  - NRZ: edge = s2 != s3.
  - RZ: edge = s2 & ~s3 (rising edge only).
- States:
  - IDLE: all counters cleared, outputs inactive. If enable=1, go to HUNT next cycle.
  - HUNT: wait for an edge. On edge: go to TRACK, phase<=1, run<=0, locked<=1.
  - TRACK: phase counts 0..OSR-1 and wraps.
    - Any edge forces phase<=1 (hard resync; the edge cycle counts as phase 0) and clears run.
  - enable=0 in any state: go to IDLE next cycle. locked and strobes clear next cycle; d_out holds its value.
- Sampling in TRACK (strobes are registered and assert the cycle after the sampling phase):
  - NRZ: at phase==OSR/2, d_out<=s2, d_valid<=1.
  - RZ: at phase==OSR/4, capture h1=s2. At phase==3*OSR/4, evaluate h1 with h2=s2:
    - h1=1, h2=0: d_out<=1.
    - h1=0, h2=0: d_out<=0.
    - h2=1 (either h1): d_out<=0 and framing_err<=1.
    - d_valid<=1 in all three cases.
- Run limit: at each wrap (phase==OSR-1) with no edge that cycle, run increments. If the incremented run would equal MAX_RUN, go to HUNT instead and set locked<=0. No d_valid is issued after lock drops.
- Resync precedence: an edge on the same cycle as a sampling phase still samples (using the current s2), then phase<=1.
- Widths: phase is $clog2(OSR) bits; run is $clog2(MAX_RUN+1) bits. No overflow is possible.
- Latency: a line_in transition is visible on s2 two clocks after capture. In NRZ, the first d_valid after lock arrives OSR/2 cycles after the lock edge is registered.

Decomposition:
- Package line_dec_pkg holds:
  - the state enum (IDLE, HUNT, TRACK);
  - mode constants MODE_NRZ=0 and MODE_RZ=1;
  - helper functions for the sample phases (OSR/4, OSR/2, 3*OSR/4).
- One sub-module, sync_2ff: 1-bit two-flop synchronizer with asynchronous active-low reset, reused for line_in.

Test Plan:
- Reset pulse in mid-TRACK (OSR=8) -> all outputs 0 immediately; state IDLE; after release and enable=1, locked stays 0 until a new edge.
- NRZ, enable=1, line_in pattern 0,1,1,1,0 at 8 cycles/bit -> locked rises on the first 0->1 edge; d_valid every 8 cycles; d_out = 1,1,1,0. Downstream recognizer asserts its d_out on the third 1.
- RZ, bits 1,1,0,1, each 1 a 4-cycle high pulse at the start of the bit -> d_out = 1,1,0,1 with d_valid every 8 cycles; framing_err stays 0.
- RZ, high pulse in the second half only (cycles 4..7 of a bit) while locked -> that bit gives d_out=0, d_valid=1, framing_err=1 for exactly one cycle.
- NRZ lock then line_in held at 1 (MAX_RUN=15) -> 14 further d_valid strobes with d_out=1; locked falls at the 15th edgeless wrap; then no d_valid until the next edge.
- NRZ edge arriving 2 cycles early (bit period 6) -> phase reset to 1; the next d_valid comes 4 cycles after the registered edge; no lost or duplicated bit.

Source files
------------

// File: rtl/line_dec_pkg.sv
// Shared types and helpers for the line bit recovery front end.
//   state_e     : decoder state (IDLE / HUNT / TRACK)
//   MODE_NRZ/RZ : values of the rz_mode input
//   sample_ph_* : sampling phases within one bit period of OSR clocks
package line_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    TRACK = 2'd2
  } state_e;

  localparam logic MODE_NRZ = 1'b0;
  localparam logic MODE_RZ  = 1'b1;

  // RZ first-half sample point
  function automatic int unsigned sample_ph_quarter(input int unsigned osr);
    return osr / 4;
  endfunction

  // NRZ mid-bit sample point
  function automatic int unsigned sample_ph_half(input int unsigned osr);
    return osr / 2;
  endfunction

  // RZ second-half sample point
  function automatic int unsigned sample_ph_3q(input int unsigned osr);
    return (3 * osr) / 4;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for an asynchronous input.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (two clocks of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/line_bit_recovery.sv
// Oversampling bit-clock recovery and NRZ/RZ decoder for an asynchronous
// serial line. Emits one decoded bit per bit period while locked.
//   clk, rst_n  : clock, asynchronous active-low reset
//   line_in     : asynchronous serial line
//   rz_mode     : 0 = NRZ, 1 = RZ (change only while enable is 0)
//   enable      : 0 forces IDLE
//   d_out       : last decoded bit, held between strobes
//   d_valid     : one-cycle strobe, new bit on d_out
//   framing_err : one-cycle strobe, RZ line high in the second half of a bit
//   locked      : high while tracking bit timing
module line_bit_recovery
  import line_dec_pkg::*;
#(
  parameter int unsigned OSR     = 8,
  parameter int unsigned MAX_RUN = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  input  logic rz_mode,
  input  logic enable,
  output logic d_out,
  output logic d_valid,
  output logic framing_err,
  output logic locked
);

  localparam int unsigned PH_W  = $clog2(OSR);
  localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);

  localparam logic [PH_W-1:0]  PH_Q1   = PH_W'(sample_ph_quarter(OSR));
  localparam logic [PH_W-1:0]  PH_HALF = PH_W'(sample_ph_half(OSR));
  localparam logic [PH_W-1:0]  PH_Q3   = PH_W'(sample_ph_3q(OSR));
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OSR - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               h1_q, h1_d;
  logic               s3_q;
  logic               d_out_q, d_out_d;
  logic               d_valid_q, d_valid_d;
  logic               framing_err_q, framing_err_d;
  logic               locked_q, locked_d;

  logic               s2;
  logic               line_edge_c;
  logic               wrap_c;
  logic               run_expire_c;
  logic [RUN_W-1:0]   run_inc_c;

  sync_2ff u_sync_line (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line_in),
    .q     (s2)
  );

  // RZ only trusts rising edges; falling edges sit mid-bit by design
  assign line_edge_c  = (rz_mode == MODE_RZ) ? (s2 & ~s3_q) : (s2 ^ s3_q);
  assign wrap_c       = (phase_q == PH_LAST);
  assign run_inc_c    = run_q + RUN_W'(1);
  assign run_expire_c = wrap_c && !line_edge_c && (run_inc_c == RUN_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = HUNT;
      HUNT:    if (line_edge_c) state_d = TRACK;
      TRACK:   if (run_expire_c) state_d = HUNT;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Phase/run counters, sampling and registered outputs
  always_comb begin
    phase_d       = phase_q;
    run_d         = run_q;
    h1_d          = h1_q;
    d_out_d       = d_out_q;
    d_valid_d     = 1'b0;
    framing_err_d = 1'b0;
    locked_d      = locked_q;
    case (state_q)
      IDLE: begin
        phase_d  = '0;
        run_d    = '0;
        h1_d     = 1'b0;
        locked_d = 1'b0;
      end
      HUNT: begin
        phase_d  = '0;
        run_d    = '0;
        h1_d     = 1'b0;
        locked_d = 1'b0;
        // The edge cycle itself is phase 0
        if (line_edge_c) begin
          phase_d  = PH_W'(1);
          locked_d = 1'b1;
        end
      end
      TRACK: begin
        phase_d = wrap_c ? '0 : phase_q + PH_W'(1);
        if (wrap_c && !line_edge_c) begin
          if (run_expire_c) begin
            run_d    = '0;
            phase_d  = '0;
            locked_d = 1'b0;
          end else begin
            run_d = run_inc_c;
          end
        end
        // Sampling uses the current s2 even when an edge arrives this cycle
        if (rz_mode == MODE_NRZ) begin
          if (phase_q == PH_HALF) begin
            d_out_d   = s2;
            d_valid_d = 1'b1;
          end
        end else begin
          if (phase_q == PH_Q1) h1_d = s2;
          if (phase_q == PH_Q3) begin
            d_out_d       = h1_q & ~s2;
            framing_err_d = s2;
            d_valid_d     = 1'b1;
          end
        end
        // Hard resync on every edge
        if (line_edge_c) begin
          phase_d = PH_W'(1);
          run_d   = '0;
        end
      end
      default: begin
        phase_d  = '0;
        run_d    = '0;
        locked_d = 1'b0;
      end
    endcase
    // Disable wins over everything except the held d_out
    if (!enable) begin
      phase_d       = '0;
      run_d         = '0;
      h1_d          = 1'b0;
      d_valid_d     = 1'b0;
      framing_err_d = 1'b0;
      locked_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_q          <= 1'b0;
      phase_q       <= '0;
      run_q         <= '0;
      h1_q          <= 1'b0;
      d_out_q       <= 1'b0;
      d_valid_q     <= 1'b0;
      framing_err_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      s3_q          <= s2;
      phase_q       <= phase_d;
      run_q         <= run_d;
      h1_q          <= h1_d;
      d_out_q       <= d_out_d;
      d_valid_q     <= d_valid_d;
      framing_err_q <= framing_err_d;
      locked_q      <= locked_d;
    end
  end

  assign d_out       = d_out_q;
  assign d_valid     = d_valid_q;
  assign framing_err = framing_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_line_bit_recovery.sv
// Directed bench for line_bit_recovery (OSR=8, MAX_RUN=15).
module tb_line_bit_recovery;
  import line_dec_pkg::*;

  localparam int unsigned OSR     = 8;
  localparam int unsigned MAX_RUN = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic line_in;
  logic rz_mode;
  logic enable;
  logic d_out;
  logic d_valid;
  logic framing_err;
  logic locked;

  line_bit_recovery #(.OSR(OSR), .MAX_RUN(MAX_RUN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_in     (line_in),
    .rz_mode     (rz_mode),
    .enable      (enable),
    .d_out       (d_out),
    .d_valid     (d_valid),
    .framing_err (framing_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges so far
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned stamp;
    logic        bit_v;
    logic        fe;
  } ev_t;

  ev_t         evq[$];
  int unsigned rise_q[$];
  int unsigned fall_q[$];
  int unsigned fe_cycles = 0;
  int unsigned fe_orphan = 0;
  logic        locked_prev = 1'b0;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (d_valid) evq.push_back('{cyc, d_out, framing_err});
    if (framing_err) begin
      fe_cycles++;
      if (!d_valid) fe_orphan++;
    end
    if (locked && !locked_prev) rise_q.push_back(cyc);
    if (!locked && locked_prev) fall_q.push_back(cyc);
    locked_prev = locked;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare one decoded-bit event (value, framing flag, time since ref_stamp)
  task automatic check_ev(input string tag, input int unsigned idx, input int unsigned ref_stamp,
                          input logic exp_bit, input logic exp_fe, input int unsigned exp_off);
    if (idx < evq.size()) begin
      check_eq({tag, "_bit"}, 32'(evq[idx].bit_v), 32'(exp_bit));
      check_eq({tag, "_fe"}, 32'(evq[idx].fe), 32'(exp_fe));
      check_eq({tag, "_time"}, evq[idx].stamp - ref_stamp, exp_off);
    end else begin
      check_eq({tag, "_missing"}, 32'(evq.size()), idx + 1);
    end
  endtask

  function automatic int unsigned rise_at(input int unsigned idx);
    return (idx < rise_q.size()) ? rise_q[idx] : 0;
  endfunction

  function automatic int unsigned fall_at(input int unsigned idx);
    return (idx < fall_q.size()) ? fall_q[idx] : 0;
  endfunction

  task automatic drive(input logic v, input int n);
    line_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    line_in = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int unsigned n0, r0, f0, fe0, c0, lk, n_ones;

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    line_in = 1'b0;
    rz_mode = MODE_NRZ;
    #12;
    check_eq("rst_d_out", 32'(d_out), 0);
    check_eq("rst_d_valid", 32'(d_valid), 0);
    check_eq("rst_framing_err", 32'(framing_err), 0);
    check_eq("rst_locked", 32'(locked), 0);

    // NRZ 0,1,1,1,0 then 1 at 8 clocks per bit
    do_reset();
    rz_mode = MODE_NRZ;
    enable  = 1'b1;
    drive(1'b0, 16);
    check_eq("nrz_hunt_unlocked", 32'(locked), 0);
    n0 = evq.size();
    r0 = rise_q.size();
    c0 = cyc;
    drive(1'b1, 8);
    drive(1'b1, 8);
    drive(1'b1, 8);
    drive(1'b0, 8);
    drive(1'b1, 8);
    check_eq("nrz_rise_count", rise_q.size() - r0, 1);
    lk = rise_at(r0);
    check_eq("nrz_lock_latency", lk - c0, 3);
    check_ev("nrz_ev0", n0 + 0, lk, 1'b1, 1'b0, OSR / 2);
    check_ev("nrz_ev1", n0 + 1, lk, 1'b1, 1'b0, OSR / 2 + OSR);
    check_ev("nrz_ev2", n0 + 2, lk, 1'b1, 1'b0, OSR / 2 + 2 * OSR);
    check_ev("nrz_ev3", n0 + 3, lk, 1'b0, 1'b0, OSR / 2 + 3 * OSR);
    check_ev("nrz_ev4", n0 + 4, lk, 1'b1, 1'b0, OSR / 2 + 4 * OSR);

    // Asynchronous reset while tracking with d_out=1
    check_eq("pre_rst_locked", 32'(locked), 1);
    check_eq("pre_rst_d_out", 32'(d_out), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_d_out", 32'(d_out), 0);
    check_eq("midrst_d_valid", 32'(d_valid), 0);
    check_eq("midrst_framing_err", 32'(framing_err), 0);
    check_eq("midrst_locked", 32'(locked), 0);
    line_in = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    n0 = evq.size();
    drive(1'b0, 24);
    check_eq("postrst_no_lock", 32'(locked), 0);
    check_eq("postrst_no_valid", evq.size() - n0, 0);
    r0 = rise_q.size();
    drive(1'b1, 6);
    check_eq("postrst_relock", 32'(locked), 1);
    check_eq("postrst_rise_count", rise_q.size() - r0, 1);

    // RZ bits 1,1,0,1, then a pulse in the second half of the next bit
    do_reset();
    rz_mode = MODE_RZ;
    enable  = 1'b1;
    drive(1'b0, 16);
    n0  = evq.size();
    r0  = rise_q.size();
    fe0 = fe_cycles;
    drive(1'b1, 4); drive(1'b0, 4);
    drive(1'b1, 4); drive(1'b0, 4);
    drive(1'b0, 8);
    drive(1'b1, 4); drive(1'b0, 4);
    check_eq("rz_clean_fe", fe_cycles - fe0, 0);
    drive(1'b0, 6); drive(1'b1, 2);
    drive(1'b0, 16);
    lk = rise_at(r0);
    check_ev("rz_ev0", n0 + 0, lk, 1'b1, 1'b0, 3 * OSR / 4);
    check_ev("rz_ev1", n0 + 1, lk, 1'b1, 1'b0, 3 * OSR / 4 + OSR);
    check_ev("rz_ev2", n0 + 2, lk, 1'b0, 1'b0, 3 * OSR / 4 + 2 * OSR);
    check_ev("rz_ev3", n0 + 3, lk, 1'b1, 1'b0, 3 * OSR / 4 + 3 * OSR);
    // Rising edge lands on the late sample point: sampled high, then resync
    check_ev("rz_frm_ev", n0 + 4, lk, 1'b0, 1'b1, 3 * OSR / 4 + 4 * OSR);
    check_ev("rz_after_frm", n0 + 5, lk, 1'b0, 1'b0, 3 * OSR / 4 + 4 * OSR + 3 * OSR / 4);
    check_eq("rz_fe_cycles", fe_cycles - fe0, 1);
    check_eq("rz_fe_orphan", fe_orphan, 0);

    // NRZ lock then line held high until the run limit drops lock
    do_reset();
    rz_mode = MODE_NRZ;
    enable  = 1'b1;
    drive(1'b0, 16);
    n0 = evq.size();
    r0 = rise_q.size();
    f0 = fall_q.size();
    drive(1'b1, MAX_RUN * OSR + 40);
    check_eq("run_valid_count", evq.size() - n0, MAX_RUN);
    n_ones = 0;
    for (int i = int'(n0); i < evq.size(); i++) if (evq[i].bit_v) n_ones++;
    check_eq("run_all_ones", n_ones, MAX_RUN);
    check_eq("run_fall_count", fall_q.size() - f0, 1);
    check_eq("run_fall_time", fall_at(f0) - rise_at(r0), MAX_RUN * OSR - 1);
    check_eq("run_unlocked", 32'(locked), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("dis_d_out_hold", 32'(d_out), 1);
    check_eq("dis_locked", 32'(locked), 0);
    enable = 1'b1;
    drive(1'b1, 8);
    check_eq("rehunt_no_valid", evq.size() - n0, MAX_RUN);
    r0 = rise_q.size();
    drive(1'b0, 8);
    check_eq("rehunt_relock", rise_q.size() - r0, 1);
    check_ev("rehunt_ev", n0 + MAX_RUN, rise_at(r0), 1'b0, 1'b0, OSR / 2);

    // NRZ with one short (6-cycle) bit: resync, no lost or extra bit
    do_reset();
    rz_mode = MODE_NRZ;
    enable  = 1'b1;
    drive(1'b0, 16);
    n0 = evq.size();
    r0 = rise_q.size();
    drive(1'b1, 8);
    drive(1'b0, 6);
    drive(1'b1, 8);
    drive(1'b0, 8);
    drive(1'b0, 2);
    lk = rise_at(r0);
    check_eq("early_ev_count", evq.size() - n0, 4);
    check_ev("early_ev0", n0 + 0, lk, 1'b1, 1'b0, OSR / 2);
    check_ev("early_ev1", n0 + 1, lk, 1'b0, 1'b0, OSR / 2 + OSR);
    check_ev("early_ev2", n0 + 2, lk, 1'b1, 1'b0, OSR / 2 + OSR + 6);
    check_ev("early_ev3", n0 + 3, lk, 1'b0, 1'b0, OSR / 2 + 2 * OSR + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
